// File: rtl/md_sched.sv
// rtl/md_sched.sv - multiply/divide scheduler owning HI/LO for the five-stage core
//
// Sequences mult/multu/div/divu issued from E, holds HI/LO, and raises the
// D-stage stall while an md-dependent instruction must wait.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous active-low reset
//   start  in   1   E-stage md instruction valid (one-cycle pulse)
//   md_op  in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   A      in  32   forwarded rs operand
//   B      in  32   forwarded rt operand
//   D_md   in   1   D-stage instruction touches HI/LO or the md unit
//   busy   out  1   multi-cycle operation in progress
//   stall  out  1   D-stage stall request
//   hi     out 32   HI register
//   lo     out 32   LO register
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] ph_q, ph_d, pl_q, pl_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        start_md;
  logic [63:0] prod_s, prod_u;
  logic        b_zero;
  logic [31:0] a_mag, b_mag, b_mag_nz, b_nz;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

  assign start_md = start && (md_op >= OP_MULT) && (md_op <= OP_DIVU);

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide is done on magnitudes so 0x80000000 / -1 wraps to
  // 0x80000000 with remainder 0 instead of hitting a signed overflow.
  assign b_zero   = (B == 32'd0);
  assign a_mag    = A[31] ? (~A + 32'd1) : A;
  assign b_mag    = B[31] ? (~B + 32'd1) : B;
  assign b_mag_nz = b_zero ? 32'd1 : b_mag;
  assign b_nz     = b_zero ? 32'd1 : B;
  assign q_mag    = a_mag / b_mag_nz;
  assign r_mag    = a_mag % b_mag_nz;
  assign q_s      = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s      = A[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u      = A / b_nz;
  assign r_u      = A % b_nz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ph_q    <= 32'd0;
      pl_q    <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    pl_d    = pl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT: begin
              ph_d    = prod_s[63:32];
              pl_d    = prod_s[31:0];
              cnt_d   = MULT_LOAD;
              state_d = RUN;
            end
            OP_MULTU: begin
              ph_d    = prod_u[63:32];
              pl_d    = prod_u[31:0];
              cnt_d   = MULT_LOAD;
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero still occupies the unit; the pending result
              // is the current HI/LO so the commit leaves them unchanged.
              if (b_zero) begin
                ph_d = hi_q;
                pl_d = lo_q;
              end else if (md_op == OP_DIV) begin
                ph_d = r_s;
                pl_d = q_s;
              end else begin
                ph_d = r_u;
                pl_d = q_u;
              end
              cnt_d   = DIV_LOAD;
              state_d = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        // start is ignored here; HI/LO cannot move until the commit.
        if (cnt_q == 4'd1) begin
          hi_d    = ph_q;
          lo_d    = pl_q;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == RUN);
  assign stall = D_md && (busy || start_md);
  assign hi    = hi_q;
  assign lo    = lo_q;

  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (!reset)
    !(busy && start && (md_op != 3'd0) && (md_op != 3'd7))
  );

endmodule
